// File: rtl/seq_alu.sv
`default_nettype none
// =============================================================================
// seq_alu : registered ALU behind a START/DONE handshake; MUL is iterative.
// Revision: 1.0
// =============================================================================
module seq_alu #(
   parameter int DATA_WIDTH = 32,
   parameter int OPRN_WIDTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [OPRN_WIDTH-1:0] OPRN,
   input  logic [DATA_WIDTH-1:0] OP1,
   input  logic [DATA_WIDTH-1:0] OP2,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [DATA_WIDTH-1:0] OUT,
   output logic                  ZERO,
   output logic                  OVF,
   output logic                  ERR
);

   localparam int MSB     = DATA_WIDTH - 1;
   localparam int SH_BITS = $clog2(DATA_WIDTH);
   localparam logic [SH_BITS-1:0] LAST_STEP = SH_BITS'(DATA_WIDTH - 1);

   localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
   localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
   localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
   localparam logic [OPRN_WIDTH-1:0] OP_SHR = OPRN_WIDTH'(4);
   localparam logic [OPRN_WIDTH-1:0] OP_SHL = OPRN_WIDTH'(5);
   localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
   localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
   localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
   localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic                  zero_q, zero_d;
   logic                  ovf_q, ovf_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
   logic [SH_BITS-1:0]    cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0] sum, diff, alu_res, acc_step;
   logic                  alu_ovf, alu_err, shift_big;
   logic [SH_BITS-1:0]    shamt;

   assign sum       = OP1 + OP2;
   assign diff      = OP1 - OP2;
   // Width is a power of two, so any set bit above the index field means OP2 >= DATA_WIDTH.
   assign shift_big = |OP2[DATA_WIDTH-1:SH_BITS];
   assign shamt     = OP2[SH_BITS-1:0];
   assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_err = 1'b0;
      case (OPRN)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (OP1[MSB] == OP2[MSB]) && (sum[MSB] != OP1[MSB]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (OP1[MSB] != OP2[MSB]) && (diff[MSB] != OP1[MSB]);
         end
         OP_MUL: alu_res = '0;
         OP_SHR: alu_res = shift_big ? '0 : (OP1 >> shamt);
         OP_SHL: alu_res = shift_big ? '0 : (OP1 << shamt);
         OP_AND: alu_res = OP1 & OP2;
         OP_OR:  alu_res = OP1 | OP2;
         OP_NOR: alu_res = ~(OP1 | OP2);
         OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
         default: alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      out_d    = out_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               if (OPRN == OP_MUL) begin
                  mcand_d  = OP1;
                  mplier_d = OP2;
                  acc_d    = '0;
                  cnt_d    = '0;
                  busy_d   = 1'b1;
                  state_d  = ST_MUL;
               end else begin
                  out_d  = alu_res;
                  zero_d = (alu_res == '0);
                  ovf_d  = alu_ovf;
                  err_d  = alu_err;
                  done_d = 1'b1;
               end
            end
         end
         ST_MUL: begin
            // One multiplier bit per cycle, LSB first, multiplicand walking left.
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               out_d   = acc_step;
               zero_d  = (acc_step == '0);
               ovf_d   = 1'b0;
               err_d   = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         out_q    <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         out_q    <= out_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign OUT  = out_q;
   assign ZERO = zero_q;
   assign OVF  = ovf_q;
   assign ERR  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// =============================================================================
// tb_seq_alu : vector table, hand sequences and random ops against a model.
// Revision: 1.0
// =============================================================================
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  oprn;
   logic        start32, start8;
   logic [31:0] op1_32, op2_32;
   logic [7:0]  op1_8, op2_8;

   logic        busy32, done32, zero32, ovf32, err32;
   logic [31:0] out32;
   logic        busy8, done8, zero8, ovf8, err8;
   logic [7:0]  out8;

   always #5 clk = ~clk;

   seq_alu #(.DATA_WIDTH(32), .OPRN_WIDTH(4)) u_dut32 (
      .CLK(clk), .RST(rst), .START(start32), .OPRN(oprn), .OP1(op1_32), .OP2(op2_32),
      .BUSY(busy32), .DONE(done32), .OUT(out32), .ZERO(zero32), .OVF(ovf32), .ERR(err32)
   );

   seq_alu #(.DATA_WIDTH(8), .OPRN_WIDTH(4)) u_dut8 (
      .CLK(clk), .RST(rst), .START(start8), .OPRN(oprn), .OP1(op1_8), .OP2(op2_8),
      .BUSY(busy8), .DONE(done8), .OUT(out8), .ZERO(zero8), .OVF(ovf8), .ERR(err8)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          narrow;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_out;
      bit          exp_z;
      bit          exp_o;
      bit          exp_e;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference semantics computed with wide signed integers.
   function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a_in,
                                 input logic [31:0] b_in, output logic [31:0] r,
                                 output bit z, output bit o, output bit e);
      longint mask = (longint'(1) << w) - 1;
      longint lim  = longint'(1) << (w - 1);
      longint a    = longint'(a_in) & mask;
      longint b    = longint'(b_in) & mask;
      longint sa   = (a >= lim) ? a - (longint'(1) << w) : a;
      longint sb   = (b >= lim) ? b - (longint'(1) << w) : b;
      longint full = 0;
      o = 0;
      e = 0;
      case (op)
         4'd1: begin full = sa + sb; o = (full >= lim) || (full < -lim); end
         4'd2: begin full = sa - sb; o = (full >= lim) || (full < -lim); end
         4'd3: full = a * b;
         4'd4: full = (b >= w) ? 0 : (a >> b);
         4'd5: full = (b >= w) ? 0 : (a << b);
         4'd6: full = a & b;
         4'd7: full = a | b;
         4'd8: full = ~(a | b);
         4'd9: full = (sa < sb) ? 1 : 0;
         default: begin full = 0; e = 1; end
      endcase
      r = 32'(full & mask);
      z = (r == 0);
   endfunction

   task automatic run_op(input bit narrow, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int inject,
                         output logic [31:0] r, output bit z, output bit o, output bit e,
                         output int lat, output int busy_cnt, output int extra);
      @(negedge clk);
      oprn = op;
      if (narrow) begin
         start8 = 1'b1; op1_8 = a[7:0]; op2_8 = b[7:0];
      end else begin
         start32 = 1'b1; op1_32 = a; op2_32 = b;
      end
      @(negedge clk);
      start32  = 1'b0;
      start8   = 1'b0;
      lat      = 1;
      busy_cnt = 0;
      while (1'b1) begin
         if (narrow ? busy8 : busy32) busy_cnt++;
         if (narrow ? done8 : done32) break;
         if (lat >= 100) break;
         @(negedge clk);
         lat++;
         if (narrow) start8 = (lat == inject);
         else        start32 = (lat == inject);
         if (lat == inject) oprn = 4'd1;
      end
      start32 = 1'b0;
      start8  = 1'b0;
      r = narrow ? {24'h0, out8} : out32;
      z = narrow ? zero8 : zero32;
      o = narrow ? ovf8 : ovf32;
      e = narrow ? err8 : err32;
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (narrow ? done8 : done32) extra++;
      end
   endtask

   logic [31:0] r, mr, a, b;
   bit          z, o, e, mz, mo, me, nar;
   int          lat, bcnt, extra, w, cnt;
   logic [3:0]  op;

   initial begin
      rst = 1'b1; start32 = 1'b0; start8 = 1'b0; oprn = '0;
      op1_32 = '0; op2_32 = '0; op1_8 = '0; op2_8 = '0;

      vecs.push_back('{0, 4'd1, 32'd9,        32'd8,        32'd17,         0, 0, 0});
      vecs.push_back('{0, 4'd2, 32'd9,        32'd8,        32'd1,          0, 0, 0});
      vecs.push_back('{0, 4'd2, 32'd8,        32'd9,        32'hFFFFFFFF,   0, 0, 0});
      vecs.push_back('{0, 4'd1, 32'h7FFFFFFF, 32'd1,        32'h80000000,   0, 1, 0});
      vecs.push_back('{0, 4'd3, 32'd9,        32'd8,        32'd72,         0, 0, 0});
      vecs.push_back('{0, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,          0, 0, 0});
      vecs.push_back('{0, 4'd4, 32'd9,        32'd1,        32'd4,          0, 0, 0});
      vecs.push_back('{0, 4'd5, 32'd9,        32'd8,        32'h900,        0, 0, 0});
      vecs.push_back('{0, 4'd5, 32'd9,        32'd40,       32'd0,          1, 0, 0});
      vecs.push_back('{0, 4'd6, 32'd9,        32'd8,        32'd8,          0, 0, 0});
      vecs.push_back('{0, 4'd7, 32'd9,        32'd8,        32'd9,          0, 0, 0});
      vecs.push_back('{0, 4'd8, 32'd9,        32'd8,        32'hFFFFFFF6,   0, 0, 0});
      vecs.push_back('{0, 4'd9, 32'd9,        32'd8,        32'd0,          1, 0, 0});
      vecs.push_back('{0, 4'd9, 32'd8,        32'd9,        32'd1,          0, 0, 0});
      vecs.push_back('{0, 4'd9, 32'hFFFFFFFF, 32'd1,        32'd1,          0, 0, 0});
      vecs.push_back('{0, 4'd0, 32'd9,        32'd8,        32'd0,          1, 0, 1});
      vecs.push_back('{0, 4'd1, 32'd2,        32'd3,        32'd5,          0, 0, 0});
      vecs.push_back('{0, 4'd15, 32'd9,       32'd8,        32'd0,          1, 0, 1});
      vecs.push_back('{0, 4'd6, 32'd12,       32'd10,       32'd8,          0, 0, 0});
      vecs.push_back('{1, 4'd3, 32'd15,       32'd17,       32'hFF,         0, 0, 0});
      vecs.push_back('{1, 4'd2, 32'h80,       32'd1,        32'h7F,         0, 1, 0});
      vecs.push_back('{1, 4'd1, 32'h7F,       32'd1,        32'h80,         0, 1, 0});
      vecs.push_back('{1, 4'd5, 32'd9,        32'd8,        32'd0,          1, 0, 0});
      vecs.push_back('{1, 4'd9, 32'hFF,       32'd1,        32'd1,          0, 0, 0});

      @(negedge clk);
      check("reset out32",  {32'h0, out32}, 64'h0);
      check("reset flags32", {58'h0, busy32, done32, zero32, ovf32, err32, 1'b0}, 64'h0);
      check("reset out8",   {56'h0, out8}, 64'h0);
      check("reset flags8", {58'h0, busy8, done8, zero8, ovf8, err8, 1'b0}, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_op(vecs[i].narrow, vecs[i].op, vecs[i].a, vecs[i].b, 0, r, z, o, e, lat, bcnt, extra);
         w = vecs[i].narrow ? 8 : 32;
         check($sformatf("vec%0d out", i),   {32'h0, r}, {32'h0, vecs[i].exp_out});
         check($sformatf("vec%0d flags", i), {61'h0, z, o, e},
               {61'h0, vecs[i].exp_z, vecs[i].exp_o, vecs[i].exp_e});
         check($sformatf("vec%0d latency", i), 64'(lat), 64'((vecs[i].op == 4'd3) ? w + 1 : 1));
         check($sformatf("vec%0d busy", i),    64'(bcnt), 64'((vecs[i].op == 4'd3) ? w : 0));
         check($sformatf("vec%0d extra done", i), 64'(extra), 64'h0);
      end

      // START(ADD) mid-MUL is ignored.
      run_op(0, 4'd3, 32'd9, 32'd8, 10, r, z, o, e, lat, bcnt, extra);
      check("mul ignore out", {32'h0, r}, 64'd72);
      check("mul ignore latency", 64'(lat), 64'd33);
      check("mul ignore extra done", 64'(extra), 64'h0);

      // Reset in the middle of a MUL.
      run_op(0, 4'd1, 32'h7FFFFFFF, 32'd1, 0, r, z, o, e, lat, bcnt, extra);
      @(negedge clk);
      oprn = 4'd3; op1_32 = 32'd9; op2_32 = 32'd8; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      repeat (4) @(negedge clk);
      check("pre-reset busy", {63'h0, busy32}, 64'd1);
      #1 rst = 1'b1;
      #1;
      check("mid-mul reset out", {32'h0, out32}, 64'h0);
      check("mid-mul reset flags", {59'h0, busy32, done32, zero32, ovf32, err32}, 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done32 || busy32) cnt++;
      end
      check("aborted mul silent", 64'(cnt), 64'h0);
      run_op(0, 4'd1, 32'd2, 32'd3, 0, r, z, o, e, lat, bcnt, extra);
      check("post-reset add out", {32'h0, r}, 64'd5);
      check("post-reset add latency", 64'(lat), 64'd1);

      for (int i = 0; i < 160; i++) begin
         nar = (i % 2) == 1;
         w   = nar ? 8 : 32;
         op  = 4'($urandom_range(0, 15));
         a   = $urandom;
         b   = $urandom;
         if ((op == 4'd4 || op == 4'd5) && $urandom_range(0, 1) == 1)
            b = $urandom_range(0, w + 3);
         if (nar) begin
            a = a & 32'hFF;
            b = b & 32'hFF;
         end
         model(w, op, a, b, mr, mz, mo, me);
         run_op(nar, op, a, b, 0, r, z, o, e, lat, bcnt, extra);
         check($sformatf("rnd%0d op%0d w%0d out", i, op, w), {32'h0, r}, {32'h0, mr});
         check($sformatf("rnd%0d op%0d w%0d flags", i, op, w), {61'h0, z, o, e}, {61'h0, mz, mo, me});
         check($sformatf("rnd%0d latency", i), 64'(lat), 64'((op == 4'd3) ? w + 1 : 1));
         check($sformatf("rnd%0d extra done", i), 64'(extra), 64'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 32-bit combinational ALU.
- Executes the same opcode set on DATA_WIDTH-bit operands behind a START/DONE handshake.
- MUL runs as an iterative shift-add unit, DATA_WIDTH cycles long; every other op completes in one cycle.
- Adds signed overflow and illegal-opcode flags. Sits between the register file read stage and write-back in the processor datapath.

Parameters:
DATA_WIDTH, 32, operand/result width (>=4, power of two)
OPRN_WIDTH, 4, opcode width

Ports:
CLK  input  1  clock, rising-edge
RST  input  1  asynchronous, active-high reset
START  input  1  request; sampled only when BUSY=0
OPRN  input  OPRN_WIDTH  opcode
OP1  input  DATA_WIDTH  operand 1
OP2  input  DATA_WIDTH  operand 2 (shift amount for shifts)
BUSY  output  1  high while a MUL iterates
DONE  output  1  one-cycle pulse: OUT/flags valid
OUT  output  DATA_WIDTH  registered result
ZERO  output  1  OUT==0 for the completed op
OVF  output  1  signed overflow (ADD/SUB only, else 0)
ERR  output  1  completed op had an illegal opcode

Behaviour:
- Reset (async, RST=1): OUT=0, ZERO=0, OVF=0, ERR=0, DONE=0, BUSY=0, FSM=IDLE, MUL accumulators cleared. Applies immediately, including mid-MUL; the aborted op never signals DONE.
- Opcodes:
  - 1 ADD, 2 SUB, 3 MUL (low DATA_WIDTH bits of product)
  - 4 SHR (logical), 5 SHL
  - 6 AND, 7 OR, 8 NOR
  - 9 SLT (signed; OUT=1 if OP1<OP2, else 0)
  - Others illegal.
- Shifts: amount is the full OP2 value; OP2 >= DATA_WIDTH gives OUT=0.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH. OVF=1 when signed overflow occurs.
- FSM states IDLE and MUL:
  - IDLE, START=1 at an edge with OPRN!=3: at that same edge OUT/ZERO/OVF/ERR load the result, DONE=1 for the next cycle, and the FSM stays IDLE. Back-to-back single-cycle ops are allowed every cycle.
  - IDLE, START=1 with OPRN=3: at that edge OP1/OP2 are latched internally, BUSY=1, iteration counter=0, FSM goes to MUL. DONE stays 0; OUT keeps its previous value.
  - MUL: each edge processes one multiplier bit (LSB first; add shifted multiplicand if set) and increments the counter.
  - MUL completion: on the DATA_WIDTH-th edge after acceptance, OUT=product, ZERO updates, OVF=0, ERR=0, DONE=1 for one cycle, BUSY=0, FSM goes to IDLE. A new START is accepted on the edge after that.
- START while BUSY=1 is ignored: not queued, no DONE.
- Operand/opcode changes during MUL have no effect (latched copies are used).
- Illegal opcode: one-cycle path; OUT=0, ZERO=1, OVF=0, ERR=1, DONE pulses.
- DONE is low in every cycle not listed above.
- OUT and the flags hold until the next completion or reset.

Test Plan:
- ADD/SUB, W=32:
  - OP1=9, OP2=8, ADD -> OUT=17, DONE one cycle after the START edge, BUSY never high.
  - SUB -> OUT=1.
  - OP1=8, OP2=9, SUB -> OUT=0xFFFFFFFF, OVF=0.
  - ADD 0x7FFFFFFF+1 -> OUT=0x80000000, OVF=1.
- MUL:
  - OP1=9, OP2=8 -> BUSY=1 for 32 cycles; OUT=72 with DONE on edge 32.
  - START(ADD) pulsed at cycle 10 is ignored: a single DONE only.
  - 0xFFFFFFFF*0xFFFFFFFF -> OUT=1.
- Shifts/logic:
  - SHR 9 by 1 -> 4; SHL 9 by 8 -> 0x900; SHL 9 by 40 -> 0, ZERO=1.
  - AND 9,8 -> 8; OR -> 9; NOR -> 0xFFFFFFF6.
- SLT:
  - 9,8 -> 0, ZERO=1.
  - 8,9 -> 1.
  - 0xFFFFFFFF,1 -> 1 (signed).
- Illegal opcode: OPRN=0 and OPRN=15 -> OUT=0, ERR=1, ZERO=1, DONE pulse. The next legal op clears ERR.
- Reset mid-MUL:
  - Assert RST at cycle 5 of a MUL -> all outputs 0 immediately, no DONE.
  - After release, ADD 2+3 -> OUT=5 with single-cycle latency.
  - Repeat at DATA_WIDTH=8: MUL 15*17 -> OUT=0xFF after 8 cycles.
